ps2_keyboard_reader: RTL and testbench
======================================

Name: ps2_keyboard_reader

Overview:
- Input-direction counterpart to the core's ASCII/VGA output path.
- Receives PS/2 keyboard frames, decodes make/break scancodes to ASCII, and buffers characters in a FIFO.
- The core pops characters through a memory-mapped read strobe, so a program can both print to and read from the text console.
- Sits beside ascii_master_controller in the top level, on CLOCK_50.

Parameters:
- FIFO_DEPTH, 16, ASCII FIFO entries; power of two, ≥ 2.
- TIMEOUT_CYCLES, 100000, idle clk cycles mid-frame before the frame is abandoned (2 ms at 50 MHz).
- WORD_SIZE, 32, width of read_data.

Ports:
- clk  input  1  system clock (CLOCK_50).
- rst  input  1  asynchronous reset, active low.
- ps2_clk  input  1  raw PS/2 clock; asynchronous to clk.
- ps2_dat  input  1  raw PS/2 data; asynchronous to clk.
- rd_en  input  1  one-cycle pop strobe from the core.
- read_data  output  WORD_SIZE  {zeros, valid[8], ascii[7:0]}; FIFO head, first-word-fall-through.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  sticky; set when a character is dropped because the FIFO is full.
- frame_error  output  1  one-cycle pulse on a parity, start, stop or timeout error.

Behaviour:
- Reset: all outputs 0, FIFO empty, modifier flags clear, FSM in IDLE; takes effect at any time, including mid-frame.
- Input sync and edge detect:
  - ps2_clk and ps2_dat each pass through a 2-FF synchronizer.
  - A falling edge is detected on synced ps2_clk; ps2_dat is sampled in that same cycle.
- Frame FSM (states IDLE, DATA, PARITY, STOP):
  - IDLE: sampled bit 0 -> DATA with bit_cnt=0. Sampled 1 -> stay in IDLE and pulse frame_error.
  - DATA: shift bits in LSB first; after 8 bits -> PARITY.
  - PARITY: check odd parity over data+parity -> STOP.
  - STOP: bit must be 1 and parity must be good, else pulse frame_error. Either way -> IDLE.
  - Valid byte: byte_valid pulses for 1 cycle, 1 cycle after the stop-bit edge.
  - Timeout: any state except IDLE with no falling edge for TIMEOUT_CYCLES -> IDLE, frame_error pulse, byte discarded.
- Scancode layer (set 2), acting on each valid byte:
  - 0xF0: set break_pending.
  - 0xE0: set ext_pending.
  - Any other byte: apply the rules below, then clear both pending flags.
  - 0x12 / 0x59 (L/R shift): shift_l / shift_r = !break_pending.
  - Other code, break_pending=1: ignored.
  - Other code, make, ext_pending=0: ascii = scancode_to_ascii(code, shift_l|shift_r). Push if nonzero.
  - Make with ext_pending=1: never pushed.
- FIFO:
  - Push 1 cycle after decode; read_data reflects the head combinationally from registered storage.
  - rd_en while empty: no effect.
  - Push while full: character dropped, overflow set, held until reset.
  - Simultaneous push and pop while full: both succeed, count unchanged.
  - Simultaneous push and pop while empty: push succeeds and the pop is ignored; count becomes 1.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: stop-bit falling edge to valid=1 on read_data is exactly 3 clk cycles (1 byte_valid + 1 decode + 1 push), measured after the 2-FF sync.

Optional Feature:
- Macro: KBD_CAPS_LOCK_EN.
- Defined:
  - Make of 0x58 toggles a caps register, reset 0.
  - Letters a–z are upper-cased when caps XOR shift = 1.
  - Non-letters are affected by shift only.
- Undefined: 0x58 maps to 0 (not pushed) and there is no caps register.

Decomposition:
- Shared package kbd_pkg:
  - Scancode constants SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59, SC_CAPS=8'h58.
  - FSM state encodings, 2-bit.
- Sub-module scancode_to_ascii: combinational ROM.
  - Inputs: code[7:0], shift.
  - Output: ascii[7:0], 0 for unmapped codes.
  - Covers letters, digits, space 0x29→0x20, enter 0x5A→0x0A, backspace 0x66→0x08.

Test Plan:
- Frame 0x1C, good parity -> 3 cycles later read_data=0x161; rd_en -> read_data=0x000, fifo_count=0.
- Bytes 12,1C,F0,1C,F0,12,1C -> FIFO holds 0x41 then 0x61; break frames push nothing.
- Frame 0x1C with bad parity -> frame_error pulse, fifo_count stays 0. A following valid 0x16 frame -> 0x31 ('1') pushed.
- Start bit, 4 data bits, then 2 ms idle -> frame_error pulse, FSM in IDLE. Next full frame 0x29 -> 0x20 pushed.
- 17 make codes of 0x1C, no reads -> fifo_count=16, overflow=1. Simultaneous push+pop at full -> count stays 16.
- rst low mid-frame at bit 5 -> all outputs 0. A fresh frame 0x5A after release -> 0x0A pushed. With KBD_CAPS_LOCK_EN: 58,F0,58,1C -> 0x41.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard reader: set-2 scancode constants,
// frame FSM encoding and the decoded-character payload.
package kbd_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

    typedef struct packed {
        logic       valid;
        logic [7:0] ascii;
    } kbd_char_t;

    function automatic logic is_letter(input logic [7:0] c);
        return ((c >= 8'h61) && (c <= 8'h7A)) || ((c >= 8'h41) && (c <= 8'h5A));
    endfunction

endpackage

// File: rtl/scancode_to_ascii.sv
// Combinational set-2 scancode to ASCII ROM; unmapped codes return 0.
module scancode_to_ascii (
    input  logic [7:0] code,
    input  logic       shift,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        case (code)
            8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
            8'h16: ascii = shift ? 8'h21 : 8'h31;
            8'h1E: ascii = shift ? 8'h40 : 8'h32;
            8'h26: ascii = shift ? 8'h23 : 8'h33;
            8'h25: ascii = shift ? 8'h24 : 8'h34;
            8'h2E: ascii = shift ? 8'h25 : 8'h35;
            8'h36: ascii = shift ? 8'h5E : 8'h36;
            8'h3D: ascii = shift ? 8'h26 : 8'h37;
            8'h3E: ascii = shift ? 8'h2A : 8'h38;
            8'h46: ascii = shift ? 8'h28 : 8'h39;
            8'h45: ascii = shift ? 8'h29 : 8'h30;
            8'h29: ascii = 8'h20;
            8'h5A: ascii = 8'h0A;
            8'h66: ascii = 8'h08;
            default: ascii = 8'h00;
        endcase
        // Letters are stored lower-case above; shift folds them to upper case
        if (shift && (ascii >= 8'h61) && (ascii <= 8'h7A)) begin
            ascii = ascii & 8'hDF;
        end
    end

endmodule

// File: rtl/ps2_keyboard_reader.sv
// PS/2 keyboard receiver: frame capture, set-2 make/break decode, ASCII FIFO.
// Optional caps-lock support is enabled with `define KBD_CAPS_LOCK_EN.
module ps2_keyboard_reader
    import kbd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned WORD_SIZE      = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ps2_clk,
    input  logic                         ps2_dat,
    input  logic                         rd_en,
    output logic [WORD_SIZE-1:0]         read_data,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow,
    output logic                         frame_error
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    // Input synchronizers; the third ps2_clk stage is the edge-detect history
    logic [2:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       fall_c;
    logic       bit_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_dat};
        end
    end

    assign fall_c = clk_sync_q[2] & ~clk_sync_q[1];
    assign bit_c  = dat_sync_q[1];

    // Frame FSM with idle-time watchdog
    frame_state_e  state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_ok_q;
    logic [TW-1:0] idle_cnt_q;
    logic          byte_valid_q;
    logic          frame_error_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            parity_ok_q   <= 1'b0;
            idle_cnt_q    <= '0;
            byte_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            byte_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            if ((state_q == ST_IDLE) || fall_c) begin
                idle_cnt_q <= '0;
            end else begin
                idle_cnt_q <= idle_cnt_q + TW'(1);
            end

            if ((state_q != ST_IDLE) && !fall_c && (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1))) begin
                state_q       <= ST_IDLE;
                frame_error_q <= 1'b1;
            end else if (fall_c) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!bit_c) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= 3'd0;
                        end else begin
                            frame_error_q <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {bit_c, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_ok_q <= ^{bit_c, shift_q};
                        state_q     <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (bit_c && parity_ok_q) begin
                            byte_valid_q <= 1'b1;
                        end else begin
                            frame_error_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Scancode layer: modifier tracking and character decode
    logic      break_q, break_d;
    logic      ext_q, ext_d;
    logic      shift_l_q, shift_l_d;
    logic      shift_r_q, shift_r_d;
    kbd_char_t push_q, push_d;
    logic [7:0] rom_ascii_c;
    logic [7:0] ascii_c;
`ifdef KBD_CAPS_LOCK_EN
    logic      caps_q, caps_d;
`endif

    scancode_to_ascii u_rom (
        .code  (shift_q),
        .shift (shift_l_q | shift_r_q),
        .ascii (rom_ascii_c)
    );

    always_comb begin
        break_d   = break_q;
        ext_d     = ext_q;
        shift_l_d = shift_l_q;
        shift_r_d = shift_r_q;
        push_d    = '0;
        ascii_c   = rom_ascii_c;
`ifdef KBD_CAPS_LOCK_EN
        caps_d = caps_q;
        // Caps inverts the case chosen by shift, letters only
        if (caps_q && is_letter(rom_ascii_c)) begin
            ascii_c = rom_ascii_c ^ 8'h20;
        end
`endif
        if (byte_valid_q) begin
            if (shift_q == SC_BREAK) begin
                break_d = 1'b1;
            end else if (shift_q == SC_EXT) begin
                ext_d = 1'b1;
            end else begin
                break_d = 1'b0;
                ext_d   = 1'b0;
                if (shift_q == SC_LSHIFT) begin
                    shift_l_d = !break_q;
                end else if (shift_q == SC_RSHIFT) begin
                    shift_r_d = !break_q;
                end else if (!break_q && !ext_q) begin
`ifdef KBD_CAPS_LOCK_EN
                    if (shift_q == SC_CAPS) begin
                        caps_d = !caps_q;
                    end
`endif
                    push_d.valid = (ascii_c != 8'h00);
                    push_d.ascii = ascii_c;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            break_q   <= 1'b0;
            ext_q     <= 1'b0;
            shift_l_q <= 1'b0;
            shift_r_q <= 1'b0;
            push_q    <= '0;
`ifdef KBD_CAPS_LOCK_EN
            caps_q    <= 1'b0;
`endif
        end else begin
            break_q   <= break_d;
            ext_q     <= ext_d;
            shift_l_q <= shift_l_d;
            shift_r_q <= shift_r_d;
            push_q    <= push_d;
`ifdef KBD_CAPS_LOCK_EN
            caps_q    <= caps_d;
`endif
        end
    end

    // Character FIFO, first-word-fall-through
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          full_c;
    logic          empty_c;
    logic          pop_c;
    logic          wr_c;

    assign full_c  = (count_q == CW'(FIFO_DEPTH));
    assign empty_c = (count_q == '0);
    assign pop_c   = rd_en && !empty_c;
    assign wr_c    = push_q.valid && (!full_c || pop_c);

    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem_q[wr_ptr_q] <= push_q.ascii;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_c, pop_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (push_q.valid && !wr_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign read_data   = WORD_SIZE'({!empty_c, (empty_c ? 8'h00 : mem_q[rd_ptr_q])});
    assign fifo_count  = count_q;
    assign overflow    = overflow_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_keyboard_reader.sv
// Directed bench for ps2_keyboard_reader: PS/2 frames driven bit by bit,
// FIFO contents and error pulses checked against hand-computed values.
module tb_ps2_keyboard_reader;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned TMO   = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic        rd_en = 1'b0;
    logic [31:0] read_data;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic        frame_error;

    int n_tests = 0;
    int n_fail  = 0;
    int err_pulses = 0;

    ps2_keyboard_reader #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .WORD_SIZE      (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .rd_en       (rd_en),
        .read_data   (read_data),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_error) err_pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // mode 0: plain frame, 1: check push latency, 2: pop in the push cycle
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int mode);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_dat = 1'b1;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        if (mode == 1) begin
            repeat (4) @(negedge clk);
            check_eq("latency_2cyc", 32'(read_data[8]), 0);
            @(negedge clk);
            check_eq("latency_3cyc", 32'(read_data[8]), 1);
            repeat (5) @(negedge clk);
        end else if (mode == 2) begin
            repeat (4) @(negedge clk);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            repeat (5) @(negedge clk);
        end else begin
            repeat (10) @(negedge clk);
        end
        ps2_clk = 1'b1;
        repeat (15) @(negedge clk);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] exp);
        check_eq(tag, read_data, exp);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] seq_shift [7] = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    logic [7:0] seq_mix   [8] = '{8'hE0, 8'h1C, 8'h12, 8'h16, 8'hF0, 8'h12, 8'h66, 8'h45};
    logic [7:0] seq_caps  [4] = '{8'h58, 8'hF0, 8'h58, 8'h1C};

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int e0;
        logic [31:0] caps_exp;
        repeat (3) @(negedge clk);
        check_eq("rst_read_data", read_data, 0);
        check_eq("rst_count", 32'(fifo_count), 0);
        check_eq("rst_overflow", 32'(overflow), 0);
        check_eq("rst_frame_error", 32'(frame_error), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Single make of 'a'
        send_frame(8'h1C, 1'b0, 1);
        check_eq("a_head", read_data, 32'h161);
        check_eq("a_count", 32'(fifo_count), 1);
        pop_expect("a_pop", 32'h161);
        check_eq("a_empty_data", read_data, 0);
        check_eq("a_empty_count", 32'(fifo_count), 0);

        // Shift make/break handling
        foreach (seq_shift[i]) send_frame(seq_shift[i], 1'b0, 0);
        check_eq("shift_count", 32'(fifo_count), 2);
        pop_expect("shift_upper", 32'h141);
        pop_expect("shift_lower", 32'h161);
        check_eq("shift_drained", 32'(fifo_count), 0);

        // Bad parity, then recovery
        e0 = err_pulses;
        send_frame(8'h1C, 1'b1, 0);
        check_eq("parity_err_pulse", 32'(err_pulses - e0), 1);
        check_eq("parity_count", 32'(fifo_count), 0);
        send_frame(8'h16, 1'b0, 0);
        pop_expect("parity_recover", 32'h131);

        // Start bit sampled high
        e0 = err_pulses;
        ps2_bit(1'b1);
        repeat (10) @(negedge clk);
        check_eq("start_err_pulse", 32'(err_pulses - e0), 1);

        // Mid-frame timeout, then a clean frame
        e0 = err_pulses;
        send_partial(8'h29, 4);
        repeat (TMO + 100) @(negedge clk);
        check_eq("timeout_err_pulse", 32'(err_pulses - e0), 1);
        check_eq("timeout_count", 32'(fifo_count), 0);
        send_frame(8'h29, 1'b0, 0);
        check_eq("timeout_recover_err", 32'(err_pulses - e0), 1);
        pop_expect("timeout_space", 32'h120);

        // Fill past capacity
        for (int i = 0; i < 17; i++) send_frame(8'h1C, 1'b0, 0);
        check_eq("full_count", 32'(fifo_count), DEPTH);
        check_eq("full_overflow", 32'(overflow), 1);
        send_frame(8'h1C, 1'b0, 2);
        check_eq("full_push_pop_count", 32'(fifo_count), DEPTH);
        pop_expect("full_head", 32'h161);
        check_eq("full_after_pop", 32'(fifo_count), DEPTH - 1);

        // Reset in the middle of a frame
        send_partial(8'h5A, 5);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("midrst_read_data", read_data, 0);
        check_eq("midrst_count", 32'(fifo_count), 0);
        check_eq("midrst_overflow", 32'(overflow), 0);
        check_eq("midrst_frame_error", 32'(frame_error), 0);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h5A, 1'b0, 0);
        pop_expect("midrst_enter", 32'h10A);

        // Extended code, shifted digit, backspace, digit
        foreach (seq_mix[i]) send_frame(seq_mix[i], 1'b0, 0);
        check_eq("mix_count", 32'(fifo_count), 3);
        pop_expect("mix_bang", 32'h121);
        pop_expect("mix_backspace", 32'h108);
        pop_expect("mix_zero", 32'h130);

        // Caps lock toggle, then 'a'
`ifdef KBD_CAPS_LOCK_EN
        caps_exp = 32'h141;
`else
        caps_exp = 32'h161;
`endif
        foreach (seq_caps[i]) send_frame(seq_caps[i], 1'b0, 0);
        check_eq("caps_count", 32'(fifo_count), 1);
        pop_expect("caps_a", caps_exp);
        check_eq("final_overflow", 32'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
